// File: rtl/cdc_sender_pkg.sv
// Shared types and default sizing for the CDC word sender and its FIFO.
package cdc_sender_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo
    import cdc_sender_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) wptr_d = wptr_q + AW'(1);
        if (pop_ok)  rptr_d = rptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cdc_word_sender.sv
// Queues local words and hands them one at a time to a CDC receiver using a
// launch pulse plus a four-phase acknowledge, with a bounded wait per phase.
module cdc_word_sender
    import cdc_sender_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                   clka,
    input  logic                   rsta,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       dataa,
    output logic                   new_dataa,
    input  logic                   acka,
    input  logic                   clr_err,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned CW = cnt_width(ACK_TIMEOUT);

    state_e           state_q;
    logic [WIDTH-1:0] dataa_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_rdata;
    logic             ack_expired;
    logic             timeout_set;

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clka),
        .rst_i  (rsta),
        .push_i (fifo_push),
        .wdata_i(in_data),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_rdata),
        .level_o(level),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    // A stale acknowledge from a previous transfer blocks the next launch.
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && !acka;

    assign ack_expired = (cnt_q == CW'(ACK_TIMEOUT));
    assign timeout_set = ack_expired &&
                         (((state_q == ST_WAIT_HI) && !acka) ||
                          ((state_q == ST_WAIT_LO) &&  acka));

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= ST_IDLE;
            dataa_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        dataa_q <= fifo_rdata;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (acka) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_LO;
                    end else if (ack_expired) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!acka || ack_expired) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (timeout_set) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign dataa       = dataa_q;
    assign new_dataa   = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_word_sender.sv
// Directed bench for cdc_word_sender: a scripted receiver answers launch
// pulses, a monitor records every pulse, and each task checks its scenario.
module tb_cdc_word_sender;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned ACK_TIMEOUT = 8;

    logic             clka = 1'b0;
    logic             rsta = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] dataa;
    logic             new_dataa;
    logic             acka = 1'b0;
    logic             clr_err = 1'b0;
    logic [2:0]       level;
    logic             busy;
    logic             timeout_err;

    int               errors = 0;
    int               checks = 0;
    int               pulses = 0;
    logic [7:0]       got[$];
    logic             hold_ack = 1'b0;
    logic             resp_en = 1'b0;

    cdc_word_sender #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clka       (clka),
        .rsta       (rsta),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dataa      (dataa),
        .new_dataa  (new_dataa),
        .acka       (acka),
        .clr_err    (clr_err),
        .level      (level),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Receiver: ack rises 2 cycles after a pulse and falls 6 cycles later.
    initial forever begin
        @(posedge clka);
        #1;
        if (hold_ack) begin
            acka = 1'b1;
        end else if (resp_en && new_dataa === 1'b1) begin
            acka = 1'b0;
            repeat (2) begin @(posedge clka); #1; end
            acka = 1'b1;
            repeat (6) begin @(posedge clka); #1; end
            acka = 1'b0;
        end else begin
            acka = 1'b0;
        end
    end

    initial forever begin
        @(posedge clka);
        #2;
        if (new_dataa === 1'b1) begin
            pulses++;
            got.push_back(dataa);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic test_reset();
        rsta = 1'b1;
        repeat (3) tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (new_dataa !== 1'b0) begin errors++; $display("FAIL reset_new_dataa got=%b exp=0", new_dataa); end
        checks++; if (dataa !== 8'h00) begin errors++; $display("FAIL reset_dataa got=%h exp=00", dataa); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
        rsta = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_empty_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_word();
        int n;
        int bad;
        int p0;
        p0 = pulses;
        resp_en = 1'b1;
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        checks++; if (new_dataa !== 1'b0) begin errors++; $display("FAIL single_early_pulse got=%b exp=0", new_dataa); end
        tick();
        checks++; if (new_dataa !== 1'b1) begin errors++; $display("FAIL single_pulse got=%b exp=1", new_dataa); end
        checks++; if (dataa !== 8'hA5) begin errors++; $display("FAIL single_dataa got=%h exp=a5", dataa); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_popped got=%0d exp=0", level); end
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
            if (busy === 1'b1 && (new_dataa !== 1'b0 || dataa !== 8'hA5)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_hold got=%0d bad cycles exp=0", bad); end
        checks++; if (n !== 9) begin errors++; $display("FAIL single_busy_len got=%0d exp=9", n); end
        checks++; if (dataa !== 8'hA5) begin errors++; $display("FAIL single_dataa_after got=%h exp=a5", dataa); end
        repeat (3) tick();
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL single_pulse_count got=%0d exp=1", pulses - p0); end
    endtask

    task automatic test_stale_ack();
        int bad;
        int n;
        resp_en = 1'b0;
        hold_ack = 1'b1;
        rsta = 1'b1;
        repeat (2) tick();
        rsta = 1'b0;
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bad = 0;
        repeat (5) begin
            tick();
            if (new_dataa !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stale_no_launch got=%0d bad cycles exp=0", bad); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL stale_level got=%0d exp=1", level); end
        hold_ack = 1'b0;
        resp_en = 1'b1;
        tick();
        checks++; if (new_dataa !== 1'b0) begin errors++; $display("FAIL stale_edge_pulse got=%b exp=0", new_dataa); end
        tick();
        checks++; if (new_dataa !== 1'b1) begin errors++; $display("FAIL stale_release_pulse got=%b exp=1", new_dataa); end
        checks++; if (dataa !== 8'h3C) begin errors++; $display("FAIL stale_dataa got=%h exp=3c", dataa); end
        n = 0;
        while (busy === 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stale_done got=%b exp=0", busy); end
    endtask

    task automatic test_burst();
        int n;
        got.delete();
        resp_en = 1'b0;
        hold_ack = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL burst_full_level got=%0d exp=4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL burst_in_ready got=%b exp=0", in_ready); end
        in_data = 8'h05;
        repeat (3) tick();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL burst_no_overflow got=%0d exp=4", level); end
        hold_ack = 1'b0;
        resp_en = 1'b1;
        tick();
        tick();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL burst_first_pop got=%0d exp=3", level); end
        checks++; if (dataa !== 8'h01) begin errors++; $display("FAIL burst_first_dataa got=%h exp=01", dataa); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_after_pop got=%b exp=1", in_ready); end
        tick();
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL burst_fifth_push got=%0d exp=4", level); end
        in_valid = 1'b0;
        n = 0;
        while ((got.size() < 5 || busy === 1'b1) && n < 400) begin tick(); n++; end
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL burst_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d] got=%h exp=%h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp_q[$];
        int n;
        got.delete();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        resp_en = 1'b0;
        hold_ack = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_data = exp_q[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL pp_level_before got=%0d exp=3", level); end
        hold_ack = 1'b0;
        resp_en = 1'b1;
        tick();
        in_data = exp_q[3]; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL pp_level_same got=%0d exp=3", level); end
        checks++; if (new_dataa !== 1'b1) begin errors++; $display("FAIL pp_pulse got=%b exp=1", new_dataa); end
        n = 0;
        while ((got.size() < 4 || busy === 1'b1) && n < 400) begin tick(); n++; end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL pp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL pp_order[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int n;
        resp_en = 1'b0;
        hold_ack = 1'b0;
        in_data = 8'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (dataa !== 8'h77) begin errors++; $display("FAIL to_dataa got=%h exp=77", dataa); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            if (busy === 1'b1) n++;
        end
        checks++; if (n !== 9) begin errors++; $display("FAIL to_wait_cycles got=%0d exp=9", n); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set got=%b exp=1", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got=%b exp=0", busy); end
        in_data = 8'h88; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (new_dataa !== 1'b1) begin errors++; $display("FAIL to_next_launch got=%b exp=1", new_dataa); end
        checks++; if (dataa !== 8'h88) begin errors++; $display("FAIL to_next_dataa got=%h exp=88", dataa); end
        clr_err = 1'b1;
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins got=%b exp=1", timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear_after got=%b exp=0", timeout_err); end
        clr_err = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        int p0;
        resp_en = 1'b0;
        hold_ack = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hA1 + 8'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        hold_ack = 1'b0;
        resp_en = 1'b1;
        tick();
        tick();
        n = 0;
        while (acka !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        checks++; if (acka !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rm_in_wait_lo got acka=%b busy=%b exp 1 1", acka, busy); end
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL rm_queued got=%0d exp=2", level); end
        p0 = pulses;
        #2 rsta = 1'b1;
        #1;
        checks++; if (new_dataa !== 1'b0) begin errors++; $display("FAIL rm_new_dataa got=%b exp=0", new_dataa); end
        checks++; if (dataa !== 8'h00) begin errors++; $display("FAIL rm_dataa got=%h exp=00", dataa); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rm_level got=%0d exp=0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
        tick();
        rsta = 1'b0;
        resp_en = 1'b0;
        repeat (30) tick();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL rm_no_pulses got=%0d exp=%0d", pulses, p0); end
        checks++; if (busy !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rm_stays_idle got busy=%b level=%0d exp 0 0", busy, level); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stale_ack();
        test_burst();
        test_simul_push_pop();
        test_timeout();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
